// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART transceiver.
package uart_pkg;

  typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_t;
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_t;

  // Widest legal frame data; narrower data is zero-extended before parity.
  localparam int unsigned MaxDataBits = 9;

  function automatic logic par_calc(logic [MaxDataBits-1:0] data, logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with occupancy count; Depth must be a power of two.
module uart_sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         rdata_o,
  output logic [$clog2(Depth):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] DepthL = (PtrW+1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [PtrW:0]    level_q, level_d;
  logic             push_ok, pop_ok;

  assign full_o  = (level_q == DepthL);
  assign empty_o = (level_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rptr_q];
  assign level_o = level_q;

  always_comb begin
    level_d = level_q + (PtrW+1)'(push_ok) - (PtrW+1)'(pop_ok);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + PtrW'(1);
      if (pop_ok)  rptr_q <= rptr_q + PtrW'(1);
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_xcvr_param.sv
// UART transceiver: FIFO-buffered serialiser and mid-bit sampling receiver,
// runtime baud divisor, compile-time frame format.
module uart_xcvr_param
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  input  logic [DATA_BITS-1:0]          tx_data,
  output logic                          ser_tx,
  output logic                          tx_busy,
  output logic                          tx_finish,
  output logic [$clog2(FIFO_DEPTH):0]   tx_level,
  input  logic                          ser_rx,
  output logic                          rx_valid,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_parity_err,
  output logic                          rx_frame_err
);

  localparam int unsigned BitW = 4;
  localparam logic [BitW-1:0] LastData = BitW'(DATA_BITS - 1);
  localparam logic [BitW-1:0] LastStop = BitW'(STOP_BITS - 1);
  localparam logic ParEn  = (PARITY_EN != 0);
  localparam logic OddPar = (PARITY_ODD != 0);

  logic                 fifo_pop, fifo_full, fifo_empty;
  logic [DATA_BITS-1:0] fifo_rdata;

  uart_sync_fifo #(
    .Width (DATA_BITS),
    .Depth (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (tx_valid),
    .wdata_i (tx_data),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .level_o (tx_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // ---------------- TX ----------------
  tx_state_t            tx_state_q, tx_state_d;
  logic [DIV_W-1:0]     tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [BitW-1:0]      tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d, ser_tx_q, ser_tx_d, tx_finish_q, tx_finish_d;

  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_div_d    = tx_div_q;
    tx_bit_d    = tx_bit_q;
    tx_shift_d  = tx_shift_q;
    tx_par_d    = tx_par_q;
    tx_finish_d = 1'b0;
    fifo_pop    = 1'b0;
    case (tx_state_q)
      TxIdle: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          tx_shift_d = fifo_rdata;
          tx_par_d   = par_calc(MaxDataBits'(fifo_rdata), OddPar);
          tx_div_d   = baud_div;
          tx_cnt_d   = baud_div;
          tx_state_d = TxStart;
        end
      end
      default: begin
        if (tx_cnt_q != '0) begin
          tx_cnt_d = tx_cnt_q - DIV_W'(1);
        end else begin
          tx_cnt_d = tx_div_q;
          tx_bit_d = tx_bit_q + BitW'(1);
          case (tx_state_q)
            TxStart: begin
              tx_bit_d   = '0;
              tx_state_d = TxData;
            end
            TxData: begin
              tx_shift_d = tx_shift_q >> 1;
              if (tx_bit_q == LastData) begin
                tx_bit_d   = '0;
                tx_state_d = ParEn ? TxParity : TxStop;
              end
            end
            TxParity: begin
              tx_bit_d   = '0;
              tx_state_d = TxStop;
            end
            TxStop: begin
              if (tx_bit_q == LastStop) begin
                tx_finish_d = 1'b1;
                tx_state_d  = TxIdle;
              end
            end
            default: tx_state_d = TxIdle;
          endcase
        end
      end
    endcase
    // Line level is registered from the next state so ser_tx is glitch-free.
    case (tx_state_d)
      TxStart:  ser_tx_d = 1'b0;
      TxData:   ser_tx_d = tx_shift_d[0];
      TxParity: ser_tx_d = tx_par_d;
      default:  ser_tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state_q  <= TxIdle;
      tx_cnt_q    <= '0;
      tx_div_q    <= '0;
      tx_bit_q    <= '0;
      tx_shift_q  <= '0;
      tx_par_q    <= 1'b0;
      ser_tx_q    <= 1'b1;
      tx_finish_q <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_div_q    <= tx_div_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      tx_par_q    <= tx_par_d;
      ser_tx_q    <= ser_tx_d;
      tx_finish_q <= tx_finish_d;
    end
  end

  assign ser_tx    = ser_tx_q;
  assign tx_finish = tx_finish_q;
  assign tx_ready  = ~fifo_full;
  assign tx_busy   = (tx_state_q != TxIdle) | ~fifo_empty;

  // ---------------- RX ----------------
  rx_state_t            rx_state_q, rx_state_d;
  logic                 rx_s1_q, rx_s2_q, rx_prev_q;
  logic [DIV_W-1:0]     rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [DIV_W:0]       rx_half;
  logic [BitW-1:0]      rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
  logic                 rx_par_q, rx_par_d, rx_valid_q, rx_valid_d;
  logic                 rx_perr_q, rx_perr_d, rx_ferr_q, rx_ferr_d;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_div_d   = rx_div_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_par_d   = rx_par_q;
    rx_data_d  = rx_data_q;
    rx_perr_d  = rx_perr_q;
    rx_ferr_d  = rx_ferr_q;
    rx_valid_d = 1'b0;
    rx_half    = ({1'b0, baud_div} + (DIV_W+1)'(1)) >> 1;
    case (rx_state_q)
      RxIdle: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_div_d   = baud_div;
          rx_cnt_d   = DIV_W'(rx_half - (DIV_W+1)'(1));
          rx_state_d = RxStart;
        end
      end
      default: begin
        if (rx_cnt_q != '0) begin
          rx_cnt_d = rx_cnt_q - DIV_W'(1);
        end else begin
          rx_cnt_d = rx_div_q;
          case (rx_state_q)
            RxStart: begin
              rx_bit_d   = '0;
              rx_state_d = rx_s2_q ? RxIdle : RxData;
            end
            RxData: begin
              rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
              rx_bit_d   = rx_bit_q + BitW'(1);
              if (rx_bit_q == LastData) rx_state_d = ParEn ? RxParity : RxStop;
            end
            RxParity: begin
              rx_par_d   = rx_s2_q;
              rx_state_d = RxStop;
            end
            RxStop: begin
              // Only the first stop bit is checked; back to idle for quick resync.
              rx_valid_d = 1'b1;
              rx_data_d  = rx_shift_q;
              rx_ferr_d  = ~rx_s2_q;
              rx_perr_d  = ParEn & (par_calc(MaxDataBits'(rx_shift_q), OddPar) != rx_par_q);
              rx_state_d = RxIdle;
            end
            default: rx_state_d = RxIdle;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_div_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_par_q   <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_s1_q    <= ser_rx;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_div_q   <= rx_div_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_par_q   <= rx_par_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_perr_q  <= rx_perr_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  assign rx_valid      = rx_valid_q;
  assign rx_data       = rx_data_q;
  assign rx_parity_err = rx_perr_q;
  assign rx_frame_err  = rx_ferr_q;

endmodule

// File: tb/tb_uart_xcvr_param.sv
// Directed bench: an 8N1 instance and an 8E1 instance, baud_div = 3 (4 clocks/bit).
module tb_uart_xcvr_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] baud_div;

  logic       tx_valid, tx_ready, ser_tx, tx_busy, tx_finish, ser_rx, rx_valid, rx_perr, rx_ferr;
  logic [7:0] tx_data, rx_data;
  logic [2:0] tx_level;
  logic       loop_en, rx_drv;
  assign ser_rx = loop_en ? ser_tx : rx_drv;

  logic       tx_valid_p, tx_ready_p, ser_tx_p, tx_busy_p, tx_finish_p, ser_rx_p;
  logic       rx_valid_p, rx_perr_p, rx_ferr_p;
  logic [7:0] tx_data_p, rx_data_p;
  logic [2:0] tx_level_p;
  logic       loop_en_p, rx_drv_p;
  assign ser_rx_p = loop_en_p ? ser_tx_p : rx_drv_p;

  uart_xcvr_param #(
    .DATA_BITS(8), .FIFO_DEPTH(4), .DIV_W(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_data(tx_data), .ser_tx(ser_tx), .tx_busy(tx_busy), .tx_finish(tx_finish),
    .tx_level(tx_level), .ser_rx(ser_rx), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_parity_err(rx_perr), .rx_frame_err(rx_ferr)
  );

  uart_xcvr_param #(
    .DATA_BITS(8), .FIFO_DEPTH(4), .DIV_W(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)
  ) dut_p (
    .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .tx_valid(tx_valid_p),
    .tx_ready(tx_ready_p), .tx_data(tx_data_p), .ser_tx(ser_tx_p), .tx_busy(tx_busy_p),
    .tx_finish(tx_finish_p), .tx_level(tx_level_p), .ser_rx(ser_rx_p), .rx_valid(rx_valid_p),
    .rx_data(rx_data_p), .rx_parity_err(rx_perr_p), .rx_frame_err(rx_ferr_p)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int rv_cnt, fin_cnt, rvp_cnt;
  logic [7:0] rv_data [8];
  logic       rv_perr [8];
  logic       rv_ferr [8];
  int         fin_cyc [8];
  logic [7:0] rvp_data;
  logic       rvp_perr, rvp_ferr;

  // Advance one clock and log output pulses, sampling 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (rx_valid) begin
      if (rv_cnt < 8) begin
        rv_data[rv_cnt] = rx_data;
        rv_perr[rv_cnt] = rx_perr;
        rv_ferr[rv_cnt] = rx_ferr;
      end
      rv_cnt++;
    end
    if (tx_finish) begin
      if (fin_cnt < 8) fin_cyc[fin_cnt] = cyc;
      fin_cnt++;
    end
    if (rx_valid_p) begin
      rvp_data = rx_data_p;
      rvp_perr = rx_perr_p;
      rvp_ferr = rx_ferr_p;
      rvp_cnt++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic send_frame(input bit to_p, input logic [7:0] d, input bit has_par,
                            input logic par, input logic stop);
    logic [10:0] bits;
    int n;
    bits = '0;
    bits[8:1] = d;
    if (has_par) begin
      bits[9] = par;
      bits[10] = stop;
      n = 11;
    end else begin
      bits[9] = stop;
      n = 10;
    end
    for (int b = 0; b < n; b++) begin
      for (int c = 0; c < 4; c++) begin
        if (to_p) rx_drv_p = bits[b];
        else rx_drv = bits[b];
        tick();
      end
    end
    rx_drv = 1'b1;
    rx_drv_p = 1'b1;
    repeat (8) tick();
  endtask

  initial begin
    logic [9:0] fr;
    int f0, lowc;
    rst_n = 1'b0; baud_div = 16'd3;
    tx_valid = 1'b0; tx_data = '0; loop_en = 1'b0; rx_drv = 1'b1;
    tx_valid_p = 1'b0; tx_data_p = '0; loop_en_p = 1'b0; rx_drv_p = 1'b1;
    rv_cnt = 0; fin_cnt = 0; rvp_cnt = 0;
    repeat (3) tick();
    rst_n = 1'b1;
    chk("rst_tx", {ser_tx, tx_ready, tx_busy, tx_finish, tx_level}, {4'b1100, 3'd0});
    chk("rst_rx", {rx_valid, rx_perr, rx_ferr, rx_data}, 32'h0);

    // Single frame 0x0F
    tx_valid = 1'b1; tx_data = 8'h0F;
    chk("t1_ready", tx_ready, 1);
    tick();
    tx_valid = 1'b0;
    chk("t1_queued", {ser_tx, tx_busy, tx_level}, {2'b11, 3'd1});
    tick();
    fr = {1'b1, 8'h0F, 1'b0};
    for (int k = 0; k < 40; k++) begin
      chk($sformatf("t1_line%0d", k), {tx_finish, ser_tx}, {1'b0, fr[k/4]});
      tick();
    end
    chk("t1_finish", {tx_finish, tx_busy, ser_tx}, 3'b101);
    tick();
    chk("t1_finish_pulse", tx_finish, 0);
    repeat (4) tick();

    // FIFO fill: six consecutive pushes, then reset mid-DATA with two queued
    for (int i = 0; i < 6; i++) begin
      tx_valid = 1'b1; tx_data = 8'(i + 1);
      chk($sformatf("t3_ready%0d", i), tx_ready, 32'(i < 5));
      if (i == 5) chk("t3_level_full", tx_level, 4);
      tick();
    end
    tx_valid = 1'b0;
    f0 = fin_cnt;
    for (int b = 0; b < 100 && fin_cnt == f0; b++) tick();
    chk("t3_fin1_seen", fin_cnt, f0 + 1);
    chk("t3_at_fin", {tx_ready, tx_level}, {1'b0, 3'd4});
    tick();
    chk("t3_after_fin", {tx_ready, tx_level}, {1'b1, 3'd3});
    f0 = fin_cnt;
    for (int b = 0; b < 100 && fin_cnt == f0; b++) tick();
    chk("t6_fin2_seen", fin_cnt, f0 + 1);
    tick();
    chk("t6_level2", tx_level, 2);
    repeat (8) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t6_reset", {ser_tx, tx_level, tx_busy, tx_finish}, {1'b1, 3'd0, 2'b00});
    f0 = fin_cnt; lowc = 0;
    for (int b = 0; b < 60; b++) begin
      if (!ser_tx) lowc++;
      tick();
    end
    chk("t6_no_finish", fin_cnt, f0);
    chk("t6_line_idle", lowc, 0);

    // Loopback of three back-to-back frames
    loop_en = 1'b1; rv_cnt = 0; fin_cnt = 0;
    tx_valid = 1'b1; tx_data = 8'h0F; tick();
    tx_data = 8'h1E; tick();
    tx_data = 8'h3C; tick();
    tx_valid = 1'b0;
    for (int b = 0; b < 300 && (rv_cnt < 3 || fin_cnt < 3); b++) tick();
    chk("t2_rx_count", rv_cnt, 3);
    chk("t2_data0", rv_data[0], 8'h0F);
    chk("t2_data1", rv_data[1], 8'h1E);
    chk("t2_data2", rv_data[2], 8'h3C);
    chk("t2_errs", {rv_perr[0], rv_ferr[0], rv_perr[1], rv_ferr[1], rv_perr[2], rv_ferr[2]}, 0);
    chk("t2_gap01", fin_cyc[1] - fin_cyc[0], 41);
    chk("t2_gap12", fin_cyc[2] - fin_cyc[1], 41);
    chk("t2_hold", rx_data, 8'h3C);
    loop_en = 1'b0;
    repeat (4) tick();

    // Frame error, glitch rejection, resync
    rv_cnt = 0;
    send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b0);
    chk("t5_ferr_count", rv_cnt, 1);
    chk("t5_ferr_data", rv_data[0], 8'hA5);
    chk("t5_ferr_flags", {rv_ferr[0], rv_perr[0]}, 2'b10);
    rx_drv = 1'b0;
    tick();
    rx_drv = 1'b1;
    repeat (30) tick();
    chk("t5_glitch", rv_cnt, 1);
    chk("t5_glitch_hold", rx_data, 8'hA5);
    send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
    chk("t5_good_count", rv_cnt, 2);
    chk("t5_good", {rv_data[1], rv_ferr[1], rv_perr[1]}, {8'h5A, 2'b00});

    // Even parity instance
    loop_en_p = 1'b1;
    tx_valid_p = 1'b1; tx_data_p = 8'h3C;
    tick();
    tx_valid_p = 1'b0;
    for (int b = 0; b < 20 && ser_tx_p; b++) tick();
    chk("t4_start", ser_tx_p, 0);
    repeat (37) tick();
    chk("t4_par_bit", ser_tx_p, 0);
    repeat (4) tick();
    chk("t4_stop_bit", ser_tx_p, 1);
    for (int b = 0; b < 40 && rvp_cnt < 1; b++) tick();
    chk("t4_lb_count", rvp_cnt, 1);
    chk("t4_lb", {rvp_data, rvp_perr, rvp_ferr}, {8'h3C, 2'b00});
    repeat (8) tick();
    loop_en_p = 1'b0;
    send_frame(1'b1, 8'h3C, 1'b1, 1'b1, 1'b1);
    chk("t4_bad_count", rvp_cnt, 2);
    chk("t4_bad_par", {rvp_data, rvp_perr, rvp_ferr}, {8'h3C, 2'b10});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
